// File: rtl/lut_layer_sequencer.sv
// lut_layer_sequencer
//
// Time-multiplexed evaluator for one layer of FANIN-input truth-table neurons.
// All neuron tables live in one shared RAM of NUM_NEURONS x 2^FANIN words of
// OUT_BITS each. The RAM is written over the cfg port while the sequencer is
// idle. Each accepted input vector is walked through the RAM one neuron per
// cycle, and the assembled output vector is then offered on a valid/ready port.
//
// Handshake rule (both vector ports): a transfer happens on a rising edge where
// valid and ready are both high. The sender holds valid and data until then.
// ready never depends on valid.
//
// Optional feature (macro LUT_CFG_READBACK_EN): adds a table readback port
// (cfg_re / cfg_rdata / cfg_rvalid) that shares the sequencer's RAM read port.
//
// Ports:
//   clk, rst     rising-edge clock, asynchronous active-high reset
//   cfg_we       table write strobe; ignored while cfg_busy
//   cfg_addr     {neuron index, table entry}
//   cfg_wdata    table entry value
//   cfg_busy     high whenever the sequencer is not idle
//   cfg_re       (readback only) table read strobe
//   cfg_rdata    (readback only) read data, valid with cfg_rvalid
//   cfg_rvalid   (readback only) one-cycle pulse, one cycle after cfg_re
//   in_valid     input vector valid
//   in_ready     input vector ready
//   in_data      neuron k address = in_data[k*FANIN +: FANIN]
//   out_valid    output vector valid
//   out_ready    downstream accept
//   out_data     neuron k result = out_data[k*OUT_BITS +: OUT_BITS]
//   dbg_state    current FSM state (0 IDLE, 1 EVAL, 2 DRAIN, 3 DONE)

module lut_layer_sequencer #(
   parameter  int NUM_NEURONS = 8,
   parameter  int FANIN       = 8,
   parameter  int OUT_BITS    = 1,
   localparam int IDX_W       = $clog2(NUM_NEURONS),
   localparam int ADDR_W      = IDX_W + FANIN
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            cfg_we,
   input  logic [ADDR_W-1:0]               cfg_addr,
   input  logic [OUT_BITS-1:0]             cfg_wdata,
   output logic                            cfg_busy,
`ifdef LUT_CFG_READBACK_EN
   input  logic                            cfg_re,
   output logic [OUT_BITS-1:0]             cfg_rdata,
   output logic                            cfg_rvalid,
`endif
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic [NUM_NEURONS*FANIN-1:0]    in_data,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [NUM_NEURONS*OUT_BITS-1:0] out_data,
   output logic [1:0]                      dbg_state
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      EVAL  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t state;
   state_t state_nxt;

   logic [IDX_W-1:0]             idx;
   logic [IDX_W-1:0]             prev_idx;
   logic                         last_idx;
   logic [NUM_NEURONS*FANIN-1:0] in_reg;
   logic [FANIN-1:0]             cur_entry;
   logic [ADDR_W-1:0]            rd_addr;
   logic [OUT_BITS-1:0]          rd_data;
   logic                         accept;
   logic                         cfg_wr_en;
   logic                         idle;

   logic [OUT_BITS-1:0] mem [NUM_NEURONS*(2**FANIN)];

   assign idle      = (state == IDLE);
   assign last_idx  = (idx == IDX_W'(NUM_NEURONS-1));
   assign prev_idx  = idx - 1'b1;
   assign cur_entry = in_reg[int'(idx)*FANIN +: FANIN];
   assign accept    = in_valid & in_ready;
   // Writes only land while idle; anything issued while busy is dropped.
   assign cfg_wr_en = cfg_we & idle;
   assign dbg_state = state;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = EVAL;
         EVAL:    if (last_idx) state_nxt = DRAIN;
         DRAIN:   state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   // A config write in the same cycle wins over an input vector.
   always_comb begin
      in_ready  = 1'b0;
      cfg_busy  = 1'b1;
      out_valid = 1'b0;
      case (state)
         IDLE: begin
            in_ready = ~cfg_we;
            cfg_busy = 1'b0;
         end
         DONE:    out_valid = 1'b1;
         default: ;
      endcase
   end

   // ---------------- Sequencer datapath ----------------
   // The RAM read issued in EVAL cycle i returns on the next cycle, so slice
   // i is written one cycle late: during EVAL cycle i+1, or in DRAIN for the
   // last neuron.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx      <= '0;
         in_reg   <= '0;
         out_data <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  in_reg <= in_data;
                  idx    <= '0;
               end
            end
            EVAL: begin
               if (idx != '0) out_data[int'(prev_idx)*OUT_BITS +: OUT_BITS] <= rd_data;
               idx <= last_idx ? '0 : idx + 1'b1;
            end
            DRAIN: out_data[(NUM_NEURONS-1)*OUT_BITS +: OUT_BITS] <= rd_data;
            default: ;
         endcase
      end
   end

   // ---------------- Table RAM ----------------
`ifdef LUT_CFG_READBACK_EN
   // Readback borrows the sequencer read port; it is only taken in IDLE with
   // no vector pending, so the two users never collide.
   logic rd_re_acc;
   assign rd_re_acc = cfg_re & idle & ~cfg_we & ~in_valid;
   assign rd_addr   = (state == EVAL) ? {idx, cur_entry} : cfg_addr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cfg_rvalid <= 1'b0;
      else     cfg_rvalid <= rd_re_acc;
   end

   // rd_data is only meaningful to the readback port during the pulse.
   always_comb begin
      cfg_rdata = '0;
      if (cfg_rvalid) cfg_rdata = rd_data;
   end
`else
   assign rd_addr = {idx, cur_entry};
`endif

   // Not reset: contents survive rst.
   always_ff @(posedge clk) begin
      if (cfg_wr_en) mem[cfg_addr] <= cfg_wdata;
      rd_data <= mem[rd_addr];
   end

endmodule

// File: tb/tb_lut_layer_sequencer.sv
// Testbench for lut_layer_sequencer (default parameters: 8 neurons, fanin 8,
// 1 output bit). Inputs are driven 1 time unit after the rising edge, outputs
// sampled on the falling edge. Expected output vectors are queued at input
// acceptance and compared by a monitor when an output handshake occurs.

module tb_lut_layer_sequencer;

   localparam int N  = 8;
   localparam int FI = 8;

   logic          clk;
   logic          rst;
   logic          cfg_we;
   logic [10:0]   cfg_addr;
   logic [0:0]    cfg_wdata;
   logic          cfg_busy;
   logic          in_valid;
   logic          in_ready;
   logic [63:0]   in_data;
   logic          out_valid;
   logic          out_ready;
   logic [7:0]    out_data;
   logic [1:0]    dbg_state;
`ifdef LUT_CFG_READBACK_EN
   logic          cfg_re;
   logic [0:0]    cfg_rdata;
   logic          cfg_rvalid;
`endif

   lut_layer_sequencer dut (
      .clk       (clk),
      .rst       (rst),
      .cfg_we    (cfg_we),
      .cfg_addr  (cfg_addr),
      .cfg_wdata (cfg_wdata),
      .cfg_busy  (cfg_busy),
`ifdef LUT_CFG_READBACK_EN
      .cfg_re    (cfg_re),
      .cfg_rdata (cfg_rdata),
      .cfg_rvalid(cfg_rvalid),
`endif
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .dbg_state (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- bookkeeping ----------------
   int checks = 0;
   int errors = 0;
   logic [7:0] exp_q[$];
   logic       model_mem [N][256];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] model_eval(input logic [63:0] d);
      logic [7:0] r;
      logic [7:0] a;
      for (int k = 0; k < N; k++) begin
         a = d[k*FI +: FI];
         r[k] = model_mem[k][a];
      end
      return r;
   endfunction

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got %0h with empty queue at %0t", out_data, $time);
         end else begin
            check("out_data", {56'd0, out_data}, {56'd0, exp_q.pop_front()});
         end
      end
   end

   // ---------------- driver tasks (start/end 1 unit after a rising edge) ----------------
   task automatic write_cfg(input int n, input int e, input logic v);
      cfg_we    = 1'b1;
      cfg_addr  = {3'(n), 8'(e)};
      cfg_wdata = v;
      @(posedge clk); #1;
      cfg_we    = 1'b0;
      if (!cfg_busy) model_mem[n][e] = v;
   endtask

   task automatic accept_vec(input logic [63:0] d, input logic [7:0] e);
      int t;
      in_data  = d;
      in_valid = 1'b1;
      t = 0;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         t++;
         if (t > 50) begin
            check("accept_timeout", 64'(t), 64'd0);
            break;
         end
         @(posedge clk); #1;
      end
      exp_q.push_back(e);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // Called right after the accept edge; counts cycles until out_valid.
   task automatic check_latency();
      int t;
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (!out_valid && t < 40);
      check("latency", 64'(t - 1), 64'(N + 1));
      @(posedge clk); #1;
   endtask

   task automatic wait_drain();
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < 60) begin
         @(posedge clk); #1;
         t++;
      end
      check("drain", 64'(exp_q.size()), 64'd0);
   endtask

   // ---------------- stimulus table ----------------
   typedef struct {
      logic [63:0] d;
      logic [7:0]  e;
   } vec_t;

   vec_t       vecs[6];
   logic [7:0] masks[6];
   logic [7:0] snap;
   logic [63:0] rd;

   initial begin
      rst       = 1'b1;
      cfg_we    = 1'b0;
      cfg_addr  = '0;
      cfg_wdata = '0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b1;
`ifdef LUT_CFG_READBACK_EN
      cfg_re    = 1'b0;
`endif

      // Reset state
      @(negedge clk);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_data", 64'(out_data), 64'd0);
      check("rst_cfg_busy", 64'(cfg_busy), 64'd0);
      check("rst_state", 64'(dbg_state), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      @(posedge clk); #1;

      // Load tables: neuron k is 1 only at entry A5+k.
      for (int n = 0; n < N; n++)
         for (int e = 0; e < 256; e++)
            write_cfg(n, e, (e == (8'hA5 + n)) ? 1'b1 : 1'b0);

      // Build vectors: hit slices use A5+k, miss slices use 0 or A5+k+1.
      masks = '{8'h00, 8'h55, 8'h81, 8'h3C, 8'hC3, 8'hFF};
      for (int i = 0; i < 6; i++) begin
         vecs[i].e = masks[i];
         for (int k = 0; k < N; k++)
            vecs[i].d[k*FI +: FI] = masks[i][k] ? 8'(8'hA5 + k)
                                    : ((i % 2) ? 8'(8'hA6 + k) : 8'h00);
      end

      // Stall: all-zero vector held at the output for 5 cycles.
      out_ready = 1'b0;
      accept_vec(64'd0, 8'h00);
      check_latency();
      snap = out_data;
      repeat (5) begin
         @(negedge clk);
         check("stall_valid", 64'(out_valid), 64'd1);
         check("stall_data", 64'(out_data), 64'(snap));
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      wait_drain();

      // Table vectors (last one all hits -> FF)
      for (int i = 0; i < 6; i++) begin
         accept_vec(vecs[i].d, vecs[i].e);
         check_latency();
         wait_drain();
      end

      // Reset mid-EVAL with out_data still partly FF.
      accept_vec(64'd0, 8'h00);
      repeat (4) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(negedge clk);
      check("midrst_out_data", 64'(out_data), 64'd0);
      check("midrst_out_valid", 64'(out_valid), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      exp_q.delete();
      @(negedge clk);
      check("postrst_busy", 64'(cfg_busy), 64'd0);
      check("postrst_in_ready", 64'(in_ready), 64'd1);
      check("postrst_out_valid", 64'(out_valid), 64'd0);
      check("postrst_out_data", 64'(out_data), 64'd0);
      @(posedge clk); #1;

      // Write while busy is dropped.
      accept_vec(64'd0, 8'h00);
      cfg_we    = 1'b1;
      cfg_addr  = {3'd3, 8'h00};
      cfg_wdata = 1'b1;
      @(negedge clk);
      check("busy_flag", 64'(cfg_busy), 64'd1);
      @(posedge clk); #1;
      cfg_we = 1'b0;
      wait_drain();
      accept_vec(64'd0, 8'h00);
      check_latency();
      wait_drain();

      // cfg_we and in_valid together: write wins, vector follows next cycle.
      cfg_we    = 1'b1;
      cfg_addr  = {3'd3, 8'h00};
      cfg_wdata = 1'b1;
      in_valid  = 1'b1;
      in_data   = 64'd0;
      @(negedge clk);
      check("we_blocks_ready", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
      cfg_we = 1'b0;
      model_mem[3][0] = 1'b1;
      @(negedge clk);
      check("ready_after_we", 64'(in_ready), 64'd1);
      exp_q.push_back(8'h08);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check_latency();
      wait_drain();

`ifdef LUT_CFG_READBACK_EN
      write_cfg(7, 8'h3C, 1'b1);
      cfg_re   = 1'b1;
      cfg_addr = {3'd7, 8'h3C};
      @(negedge clk);
      check("rb_no_early", 64'(cfg_rvalid), 64'd0);
      @(posedge clk); #1;
      cfg_re = 1'b0;
      @(negedge clk);
      check("rb_rvalid", 64'(cfg_rvalid), 64'd1);
      check("rb_rdata", 64'(cfg_rdata), 64'd1);
      @(posedge clk); #1;
      @(negedge clk);
      check("rb_pulse", 64'(cfg_rvalid), 64'd0);
      @(posedge clk); #1;
      // Read while busy gives no pulse.
      accept_vec(64'd0, model_eval(64'd0));
      cfg_re = 1'b1;
      @(posedge clk); #1;
      cfg_re = 1'b0;
      @(negedge clk);
      check("rb_busy_drop", 64'(cfg_rvalid), 64'd0);
      @(posedge clk); #1;
      wait_drain();
`endif

      // Random vectors mixing hits and arbitrary entries.
      for (int i = 0; i < 8; i++) begin
         for (int k = 0; k < N; k++)
            rd[k*FI +: FI] = ($urandom_range(0, 1) == 1) ? 8'(8'hA5 + k) : 8'($urandom_range(0, 255));
         accept_vec(rd, model_eval(rd));
         check_latency();
         wait_drain();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Global watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
